// File: rtl/special_tile_renderer.sv
// Special tile renderer: scans up to NUM_TILES "plus"/"minus" power-up tiles
// and streams their pixels into the framebuffer write mux, one pixel per cycle.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   start                 request a frame render (sampled only when idle)
//   tile_x, tile_y        packed cell coordinates, tile k at [k*COORD_W +: COORD_W]
//   tile_kind             per tile: 1 = plus, 0 = minus
//   tile_en               per tile: 1 = draw
//   pixel_ready           framebuffer accepts the presented pixel
//   xLoc, yLoc, colour    registered pixel address and colour
//   plot                  pixel valid
//   busy                  high whenever not idle
//   done                  one-cycle completion pulse
module special_tile_renderer #(
    parameter int unsigned NUM_TILES = 2,
    parameter int unsigned COORD_W   = 5,
    parameter int unsigned LOC_W     = 9,
    parameter int unsigned CELL      = 10,
    parameter int unsigned TILE      = 9,
    parameter int unsigned X_ORIGIN  = 80,
    parameter int unsigned Y_ORIGIN  = 0,
    parameter logic [2:0]  COL_PLUS  = 3'b100,
    parameter logic [2:0]  COL_MINUS = 3'b010,
    parameter logic [2:0]  COL_BG    = 3'b111
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_TILES*COORD_W-1:0] tile_x,
    input  logic [NUM_TILES*COORD_W-1:0] tile_y,
    input  logic [NUM_TILES-1:0]         tile_kind,
    input  logic [NUM_TILES-1:0]         tile_en,
    input  logic                         pixel_ready,
    output logic [LOC_W-1:0]             xLoc,
    output logic [LOC_W-1:0]             yLoc,
    output logic [2:0]                   colour,
    output logic                         plot,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned IDX_W   = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int unsigned RC_W    = $clog2(TILE);
    localparam int unsigned BAND_LO = TILE / 3;
    localparam int unsigned BAND_HI = (2 * TILE) / 3;

    typedef enum logic [1:0] {StIdle, StSeek, StScan, StDone} state_e;

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [RC_W-1:0]              row_q, row_d, col_q, col_d;
    logic                         plot_q, plot_d;
    logic                         busy_q, done_q;
    logic [LOC_W-1:0]             xloc_q, yloc_q, xloc_d, yloc_d;
    logic [2:0]                   colour_q, colour_d;
    logic [NUM_TILES*COORD_W-1:0] tx_q, ty_q;
    logic [NUM_TILES-1:0]         kind_q, en_q;
    logic                         snap, load_pix, last_idx;

    logic [COORD_W-1:0] tx_cur, ty_cur;
    logic               kind_cur, row_in_band, col_in_band, glyph;
    logic [31:0]        xsum, ysum;

    assign last_idx = (idx_q == IDX_W'(NUM_TILES - 1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        row_d    = row_q;
        col_d    = col_q;
        plot_d   = plot_q;
        snap     = 1'b0;
        load_pix = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    snap    = 1'b1;
                    idx_d   = '0;
                    state_d = StSeek;
                end
            end
            StSeek: begin
                if (en_q[idx_q]) begin
                    row_d    = '0;
                    col_d    = '0;
                    plot_d   = 1'b1;
                    load_pix = 1'b1;
                    state_d  = StScan;
                end else if (last_idx) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            StScan: begin
                // Only an accepted pixel advances; a stalled pixel keeps its registers.
                if (plot_q && pixel_ready) begin
                    if (col_q == RC_W'(TILE - 1)) begin
                        col_d = '0;
                        if (row_q == RC_W'(TILE - 1)) begin
                            row_d  = '0;
                            plot_d = 1'b0;
                            if (last_idx) begin
                                state_d = StDone;
                            end else begin
                                idx_d   = idx_q + IDX_W'(1);
                                state_d = StSeek;
                            end
                        end else begin
                            row_d    = row_q + RC_W'(1);
                            load_pix = 1'b1;
                        end
                    end else begin
                        col_d    = col_q + RC_W'(1);
                        load_pix = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Pixel address and colour for the next presented pixel (row_d/col_d of tile idx_q).
    always_comb begin
        tx_cur      = tx_q[idx_q*COORD_W +: COORD_W];
        ty_cur      = ty_q[idx_q*COORD_W +: COORD_W];
        kind_cur    = kind_q[idx_q];
        xsum        = X_ORIGIN + 32'(tx_cur) * CELL + 32'(col_d);
        ysum        = Y_ORIGIN + 32'(ty_cur) * CELL + 32'(row_d);
        xloc_d      = xsum[LOC_W-1:0];
        yloc_d      = ysum[LOC_W-1:0];
        row_in_band = (32'(row_d) >= BAND_LO) && (32'(row_d) < BAND_HI);
        col_in_band = (32'(col_d) >= BAND_LO) && (32'(col_d) < BAND_HI);
        // Horizontal bar starts at col 2; the plus adds a vertical bar.
        glyph       = (row_in_band && (32'(col_d) >= 32'd2)) || (kind_cur && col_in_band);
        colour_d    = glyph ? (kind_cur ? COL_PLUS : COL_MINUS) : COL_BG;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            xloc_q   <= '0;
            yloc_q   <= '0;
            colour_q <= '0;
            tx_q     <= '0;
            ty_q     <= '0;
            kind_q   <= '0;
            en_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
            plot_q  <= plot_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StDone);
            if (load_pix) begin
                xloc_q   <= xloc_d;
                yloc_q   <= yloc_d;
                colour_q <= colour_d;
            end
            if (snap) begin
                tx_q   <= tile_x;
                ty_q   <= tile_y;
                kind_q <= tile_kind;
                en_q   <= tile_en;
            end
        end
    end

    assign xLoc   = xloc_q;
    assign yLoc   = yloc_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: doc/special_tile_renderer.md
Name: special_tile_renderer

Overview:
- Parametrised successor to the two-box special-item drawer. It rasterises up to NUM_TILES special tiles ("plus" or "minus" power-ups) into the VGA framebuffer pixel stream, one pixel per cycle.
- Adds a per-tile enable mask, a per-tile kind select, configurable tile geometry and origin, a `pixel_ready` backpressure handshake, and a single-cycle `done` pulse.
- Sits between the game-logic controller (drives `start`) and the framebuffer write mux (consumes `xLoc`/`yLoc`/`colour`/`plot`).

Parameters:
- NUM_TILES, 2, number of tile slots scanned per frame (1..16).
- COORD_W, 5, width of one maze cell coordinate.
- LOC_W, 9, width of the `xLoc`/`yLoc` pixel outputs.
- CELL, 10, pixel pitch of one maze cell.
- TILE, 9, drawn tile edge in pixels (3..CELL).
- X_ORIGIN, 80, pixel x offset of maze column 0.
- Y_ORIGIN, 0, pixel y offset of maze row 0.
- COL_PLUS, 3'b100, glyph colour for plus tiles.
- COL_MINUS, 3'b010, glyph colour for minus tiles.
- COL_BG, 3'b111, tile background colour.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a frame render; sampled only in IDLE.
- tile_x  in  NUM_TILES*COORD_W  cell x of tile k, at bits [k*COORD_W +: COORD_W].
- tile_y  in  NUM_TILES*COORD_W  cell y of tile k, same packing.
- tile_kind  in  NUM_TILES  1 = plus, 0 = minus, per tile.
- tile_en  in  NUM_TILES  1 = draw tile k.
- pixel_ready  in  1  framebuffer accepts the current pixel.
- xLoc  out  LOC_W  pixel x.
- yLoc  out  LOC_W  pixel y.
- colour  out  3  pixel colour.
- plot  out  1  pixel valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE; `xLoc`, `yLoc`, `colour`, `plot`, `busy`, `done` all 0; tile index and row/col counters 0. Reset in any state, including mid-tile, aborts the render with no `done`.
- All outputs are registered.
- States: IDLE, SEEK, SCAN, DONE.
- IDLE:
  - On `start`=1, snapshot `tile_x`, `tile_y`, `tile_kind`, `tile_en` into internal registers, set idx=0, go to SEEK.
  - Input changes after the snapshot are ignored until the next frame.
- SEEK (one cycle per tile slot examined, `plot`=0):
  - If en[idx]=1: load row=col=0, drive pixel (0,0) with `plot`=1, go to SCAN.
  - Else if idx=NUM_TILES-1: go to DONE.
  - Else: idx++ and stay in SEEK.
- SCAN, on `plot`&&`pixel_ready` (pixel accepted):
  - Advance in row-major order, col fastest, both counting 0..TILE-1.
  - After accepting (TILE-1,TILE-1): `plot`=0; go to DONE if idx=NUM_TILES-1, else idx++ and go to SEEK.
- SCAN, on `plot`=1 && `pixel_ready`=0: hold `xLoc`, `yLoc`, `colour` stable; the pixel is never dropped or duplicated.
- DONE: `done`=1 and `busy`=1 for exactly one cycle, then IDLE. `start` is ignored in DONE and in all busy states; it is not queued.
- Address:
  - `xLoc` = X_ORIGIN + tx*CELL + col.
  - `yLoc` = Y_ORIGIN + ty*CELL + row.
  - Computed at ≥ LOC_W+COORD_W bits and truncated modulo 2^LOC_W.
- Colour, with band B = [TILE/3, 2*TILE/3) using integer division; TILE=9 gives B = 3..5:
  - glyph = (row∈B && col≥2) || (kind=plus && col∈B).
  - `colour` = glyph ? (plus ? COL_PLUS : COL_MINUS) : COL_BG.
- Timing, `start` sampled at cycle T, `pixel_ready`=1 throughout:
  - SEEK at T+1; first `plot` at T+2.
  - Each tile is TILE² contiguous `plot` cycles.
  - Each SEEK cycle (enabled or skipped slot) is a one-cycle bubble.
  - `done` comes one cycle after the last accepted pixel.
- `tile_en`=0 for all tiles: no `plot` at all; `done` after NUM_TILES SEEK cycles.

Test Plan:
- Defaults; en=2'b11, kind=2'b01, tile0 at (0,0), tile1 at (3,2); `start` at T; `pixel_ready`=1.
  - → `plot` cycles T+2..T+82, then T+84..T+164.
  - → First pixel (80,0) 3'b111; tile0 pixel row3/col2 = (82,3) 3'b100; tile0 row0/col4 = (84,0) 3'b100; tile1 first pixel (110,20); tile1 row0/col4 3'b111, row4/col5 3'b010.
  - → `done` exactly at T+165; `busy` T+1..T+165.
- en=2'b10, same setup.
  - → tile0 skipped; first `plot` T+3 at (110,20); `done` T+84; no pixel in x<110.
- en=2'b00.
  - → `plot` never asserts; `done` at T+3; returns to IDLE at T+4.
- `pixel_ready` deasserted for 5 cycles while at pixel 40 of tile0.
  - → `xLoc`/`yLoc`/`colour` held constant, `plot`=1; exactly 162 distinct accepted pixels; `done` delayed by exactly 5 cycles.
- `start` re-asserted mid-SCAN and during DONE.
  - → ignored; coordinates changed mid-frame have no effect on emitted pixels.
- `reset`=1 at pixel 30 of tile1.
  - → next cycle all outputs 0, state IDLE, no `done`.
  - → A subsequent `start` renders the full frame from tile0.
